// File: rtl/reg_file_wb_ctrl.sv
// Phase sequencer and write-port arbiter for the 8x8 register file.
// One ALU/MEM grant per 4-phase cycle, round-robin on conflict.
module reg_file_wb_ctrl #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                 CLK,
  input  logic                 init_n,
  input  logic                 stall,
  output logic [1:0]           counter,
  input  logic                 alu_req,
  input  logic [$clog2(N)-1:0] alu_addr,
  input  logic [W-1:0]         alu_data,
  output logic                 alu_ack,
  input  logic                 mem_req,
  input  logic [$clog2(N)-1:0] mem_addr,
  input  logic [W-1:0]         mem_data,
  output logic                 mem_ack,
  output logic                 write_en,
  output logic [$clog2(N)-1:0] waddr,
  output logic [W-1:0]         data_in,
  output logic [7:0]           conflict_cnt
);

  logic last_grant;
  logic arb;
  logic both;
  logic grant;
  logic grant_mem;

  // Arb edge detect and winner selection
  always_comb begin
    arb       = (counter == 2'd0) && !stall;
    both      = alu_req && mem_req;
    grant     = 1'b0;
    grant_mem = 1'b0;
    unique case (1'b1)
      both: begin
        grant     = 1'b1;
        grant_mem = !last_grant;
      end
      mem_req && !alu_req: begin
        grant     = 1'b1;
        grant_mem = 1'b1;
      end
      alu_req && !mem_req: begin
        grant     = 1'b1;
      end
      default: ;
    endcase
  end

  // Free-running phase counter, frozen by stall
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      counter <= 2'd0;
    end else if (!stall) begin
      counter <= counter + 2'd1;
    end
  end

  // Ack pulses: set on a won arb edge, cleared on any other edge
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      alu_ack <= 1'b0;
      mem_ack <= 1'b0;
    end else begin
      alu_ack <= arb && grant && !grant_mem;
      mem_ack <= arb && grant && grant_mem;
    end
  end

  // Write port, held for the whole period after an arb edge
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      write_en <= 1'b0;
      waddr    <= '0;
      data_in  <= '0;
    end else if (arb) begin
      write_en <= grant;
      if (grant) begin
        waddr   <= grant_mem ? mem_addr : alu_addr;
        data_in <= grant_mem ? mem_data : alu_data;
      end
    end
  end

  // Round-robin memory: 0 = ALU won last, 1 = MEM won last
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      last_grant <= 1'b0;
    end else if (arb && grant) begin
      last_grant <= grant_mem;
    end
  end

  // Saturating conflict counter
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      conflict_cnt <= 8'd0;
    end else if (arb && both && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_file_wb_ctrl.sv
// Bench for reg_file_wb_ctrl.
// Expected grants queued at drive time, popped on ack.
module tb_reg_file_wb_ctrl;

  typedef struct {
    logic       is_mem;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       CLK = 1'b0;
  logic       init_n = 1'b0;
  logic       stall = 1'b0;
  logic [1:0] counter;
  logic       alu_req = 1'b0;
  logic [2:0] alu_addr = '0;
  logic [7:0] alu_data = '0;
  logic       alu_ack;
  logic       mem_req = 1'b0;
  logic [2:0] mem_addr = '0;
  logic [7:0] mem_data = '0;
  logic       mem_ack;
  logic       write_en;
  logic [2:0] waddr;
  logic [7:0] data_in;
  logic [7:0] conflict_cnt;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic exp_last = 1'b0;
  int   exp_cnt = 0;

  reg_file_wb_ctrl #(.N(8), .W(8)) dut (
    .CLK(CLK), .init_n(init_n), .stall(stall),
    .counter(counter),
    .alu_req(alu_req), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_ack(alu_ack),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack),
    .write_en(write_en), .waddr(waddr),
    .data_in(data_in), .conflict_cnt(conflict_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  // Bench model of the arbiter: push the predicted winner
  task automatic push_arb(input logic a, input logic m);
    exp_t e;
    logic w;
    if (a && m) begin
      w = !exp_last;
      if (exp_cnt < 255) exp_cnt++;
    end else begin
      w = m;
    end
    e.is_mem = w;
    e.addr = w ? mem_addr : alu_addr;
    e.data = w ? mem_data : alu_data;
    sb.push_back(e);
    exp_last = w;
  endtask

  // Advance to a negedge where counter==0 (bounded)
  task automatic sync0();
    int k;
    k = 0;
    while (counter != 2'd0 && k < 8) begin
      @(negedge CLK);
      k++;
    end
    if (counter != 2'd0) chk("sync_timeout", 0, 1);
  endtask

  // Ack monitor / scoreboard consumer
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (alu_ack && mem_ack) begin
      chk("dual_ack", 1, 0);
    end else if (alu_ack || mem_ack) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ack_src", 32'(mem_ack), 32'(e.is_mem));
        chk("ack_phase", 32'(counter), 1);
        chk("wen", 32'(write_en), 1);
        chk("waddr", 32'(waddr), 32'(e.addr));
        chk("wdata", 32'(data_in), 32'(e.data));
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_cnt", 32'(counter), 0);
    chk("rst_wen", 32'(write_en), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_data", 32'(data_in), 0);
    chk("rst_acks", 32'({alu_ack, mem_ack}), 0);
    chk("rst_conf", 32'(conflict_cnt), 0);
    @(negedge CLK);
    init_n = 1'b1;

    // Free-run sequence
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK);
      #1;
      chk("seq", 32'(counter), 32'(i % 4));
      chk("idle_wen", 32'(write_en), 0);
    end

    // Single ALU write, then stall at phase 2
    @(negedge CLK);
    sync0();
    alu_req = 1'b1;
    alu_addr = 3'd3;
    alu_data = 8'h5A;
    push_arb(1'b1, 1'b0);
    @(negedge CLK);
    chk("alu_ack_p1", 32'(alu_ack), 1);
    alu_req = 1'b0;
    @(negedge CLK);
    chk("alu_ack_clr", 32'(alu_ack), 0);
    chk("p2_cnt", 32'(counter), 2);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      chk("stall_cnt", 32'(counter), 2);
      chk("stall_wen", 32'(write_en), 1);
      chk("stall_waddr", 32'(waddr), 3);
      chk("stall_data", 32'(data_in), 32'h5A);
      chk("stall_ack", 32'({alu_ack, mem_ack}), 0);
    end
    @(negedge CLK);
    stall = 1'b0;
    @(posedge CLK);
    #1;
    chk("resume3", 32'(counter), 3);
    chk("hold_wen3", 32'(write_en), 1);
    @(posedge CLK);
    #1;
    chk("resume0", 32'(counter), 0);

    // Conflict round-robin
    @(negedge CLK);
    sync0();
    alu_req = 1'b1;
    alu_addr = 3'd2;
    alu_data = 8'h22;
    mem_req = 1'b1;
    mem_addr = 3'd1;
    mem_data = 8'h11;
    push_arb(1'b1, 1'b1);
    @(negedge CLK);
    chk("rr_mem_first", 32'(mem_ack), 1);
    mem_req = 1'b0;
    sync0();
    push_arb(1'b1, 1'b0);
    @(negedge CLK);
    chk("rr_alu_next", 32'(alu_ack), 1);
    alu_req = 1'b0;
    chk("rr_conf", 32'(conflict_cnt), 1);

    // Saturation: both request continuously
    alu_req = 1'b1;
    mem_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sync0();
      push_arb(1'b1, 1'b1);
      @(negedge CLK);
      chk("sat_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    end
    alu_req = 1'b0;
    mem_req = 1'b0;
    chk("sat_255", 32'(conflict_cnt), 255);

    // Reset mid-operation with MEM pending
    chk("pre_rst_p1", 32'(counter), 1);
    chk("pre_rst_wen", 32'(write_en), 1);
    mem_req = 1'b1;
    mem_addr = 3'd6;
    mem_data = 8'h66;
    #2;
    init_n = 1'b0;
    #1;
    chk("mrst_wen", 32'(write_en), 0);
    chk("mrst_cnt", 32'(counter), 0);
    chk("mrst_conf", 32'(conflict_cnt), 0);
    chk("mrst_ack", 32'({alu_ack, mem_ack}), 0);
    @(negedge CLK);
    init_n = 1'b1;
    exp_last = 1'b0;
    exp_cnt = 0;
    push_arb(1'b0, 1'b1);
    @(negedge CLK);
    chk("mrst_mem_ack", 32'(mem_ack), 1);
    mem_req = 1'b0;
    repeat (4) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
